dma_sram_arbiter: RTL and testbench

Downstream access controller for the DMA engines: accepts byte read/write requests from up to `NCH` DMA channels, grants one per free SRAM slot, drives the shared SRAM port and returns per-channel `ack`/`done` plus read data. It sits between DMA channel logic and the SRAM bus. The SRAM bus is time-shared with the host CPU, which owns every cycle where `slot_free` is low.

---
 rtl/dma_arb_pkg.sv | 15 +
 rtl/dma_rr_pick.sv | 53 +++++
 rtl/dma_sram_arbiter.sv | 132 +++++++++++++
 tb/tb_dma_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA-to-SRAM arbiter.
package dma_arb_pkg;

  localparam int unsigned AW_DEF = 21;
  // Wide enough for up to 8 channels.
  localparam int unsigned CH_IDW = 3;

  // One completion-pipeline entry: which channel retires and whether it read.
  typedef struct packed {
    logic              valid;
    logic [CH_IDW-1:0] id;
    logic              rnw;
  } cpl_t;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational channel picker: round-robin from ptr, or fixed priority
// (channel 0 highest) when DMA_ARB_FIXED_PRIO_EN is defined.
module dma_rr_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]    req,
  input  logic [CH_IDW-1:0] ptr,
  input  logic              slot_free,
  output logic [NCH-1:0]    gnt,
  output logic [CH_IDW-1:0] gnt_id
);

`ifdef DMA_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Find the requester closest to the priority point, grant only on a free slot.
  always_comb begin
    int best;
    int bid;
    int d;
    gnt    = '0;
    gnt_id = '0;
    best   = int'(NCH);
    bid    = 0;
    d      = 0;
`ifdef DMA_ARB_FIXED_PRIO_EN
    for (int c = int'(NCH) - 1; c >= 0; c--) begin
      if (req[c]) begin
        best = 0;
        bid  = c;
      end
    end
`else
    for (int c = 0; c < int'(NCH); c++) begin
      d = c - int'(ptr);
      if (d < 0) d = d + int'(NCH);
      if (req[c] && (d < best)) begin
        best = d;
        bid  = c;
      end
    end
`endif
    if (slot_free && (best < int'(NCH))) begin
      gnt_id = CH_IDW'(bid);
      for (int c = 0; c < int'(NCH); c++) gnt[c] = (c == bid);
    end
  end

endmodule

// File: rtl/dma_sram_arbiter.sv
// DMA channel to shared-SRAM access controller. Grants one channel per free
// SRAM slot, drives the SRAM port and returns a fixed-latency done pulse.
// Build option: DMA_ARB_FIXED_PRIO_EN selects fixed priority (no ptr).
module dma_sram_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              slot_free,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_rnw,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*8-1:0]  ch_wd,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_done,
  output logic [7:0]        ch_rd,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_wd,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rd
);

  logic [NCH-1:0]    gnt;
  logic [CH_IDW-1:0] gnt_id;
  logic [CH_IDW-1:0] ptr;
  logic              any_gnt;
  logic [AW-1:0]     sel_addr;
  logic [7:0]        sel_wd;
  logic              sel_rnw;
  cpl_t              cur;
  cpl_t              tap;
  cpl_t              pipe [RD_LAT];

  dma_rr_pick #(.NCH(NCH)) u_pick (
    .req       (ch_req),
    .ptr       (ptr),
    .slot_free (slot_free),
    .gnt       (gnt),
    .gnt_id    (gnt_id)
  );

  assign ch_ack  = rst ? '0 : gnt;
  assign any_gnt = |ch_ack;

  // Mux the winning channel's request fields (grant is one-hot).
  always_comb begin
    sel_addr = '0;
    sel_wd   = '0;
    sel_rnw  = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (gnt[i]) begin
        sel_addr = ch_addr[i*AW +: AW];
        sel_wd   = ch_wd[i*8 +: 8];
        sel_rnw  = ch_rnw[i];
      end
    end
  end

`ifdef DMA_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // Round-robin pointer: one past the last winner, held when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= (gnt_id == CH_IDW'(NCH - 1)) ? '0 : gnt_id + CH_IDW'(1);
    end
  end
`endif

  // SRAM port: capture the winner's fields; strobes last one cycle per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
    end else if (any_gnt) begin
      mem_addr <= sel_addr;
      mem_wd   <= sel_wd;
      mem_re   <= sel_rnw;
      mem_we   <= ~sel_rnw;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
    end
  end

  // Entry for the access being accepted this cycle.
  always_comb begin
    cur       = '0;
    cur.valid = any_gnt;
    cur.id    = gnt_id;
    cur.rnw   = sel_rnw;
  end

  // Completion shift register, cleared by reset so in-flight accesses vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  // Stage that retires on this edge (the live grant when RD_LAT is 1).
  always_comb begin
    tap = cur;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      if (i == int'(RD_LAT) - 2) tap = pipe[i];
    end
  end

  // Done pulse and read data; ch_rd holds across writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_done <= '0;
      ch_rd   <= '0;
    end else begin
      ch_done <= tap.valid ? (NCH'(1) << tap.id) : '0;
      if (tap.valid && tap.rnw) ch_rd <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dma_sram_arbiter.sv
// Scoreboard bench for dma_sram_arbiter (NCH=4, AW=21, RD_LAT=2).
module tb_dma_sram_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 21;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              slot_free = 1'b0;
  logic [NCH-1:0]    ch_req = '0;
  logic [NCH-1:0]    ch_rnw = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*8-1:0]  ch_wd = '0;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_done;
  logic [7:0]        ch_rd;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wd;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rd;

  dma_sram_arbiter #(.NCH(NCH), .AW(AW), .RD_LAT(2)) dut (
    .rst       (rst),
    .clk       (clk),
    .slot_free (slot_free),
    .ch_req    (ch_req),
    .ch_rnw    (ch_rnw),
    .ch_addr   (ch_addr),
    .ch_wd     (ch_wd),
    .ch_ack    (ch_ack),
    .ch_done   (ch_done),
    .ch_rd     (ch_rd),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM model: combinational read of the registered address, write on edge.
  logic [7:0] sram [256];
  bit         sram_ready = 1'b0;
  assign mem_rd = sram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 256; i++) sram[i] = (i == 0) ? 8'h5A : 8'h00;
      sram_ready = 1'b1;
    end else if (mem_we) begin
      sram[mem_addr[7:0]] = mem_wd;
    end
  end

  // Scoreboard state
  typedef struct {
    int         due;
    int         ch;
    logic       rnw;
    logic [7:0] data;
  } sb_t;

  sb_t          sbq [$];
  logic [7:0]   sb_mem [256];
  bit           sb_ready = 1'b0;
  int           cyc = 0;
  int           tb_ptr = 0;
  logic         exp_re = 1'b0;
  logic         exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]   exp_wd = '0;
  logic [7:0]   exp_rd = '0;
  int           n_rd_done = 0;
  int           n_wr_done = 0;

  function automatic int model_win(input logic [NCH-1:0] req, input int p);
    int c;
    for (int k = 0; k < int'(NCH); k++) begin
      c = (p + k) % int'(NCH);
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: mid-cycle compare of registered outputs and the combinational ack.
  always @(negedge clk) begin
    logic [NCH-1:0] exp_ack;
    logic [NCH-1:0] exp_done;
    int             win;
    int             p;
    sb_t            e;
    if (!sb_ready) begin
      for (int i = 0; i < 256; i++) sb_mem[i] = (i == 0) ? 8'h5A : 8'h00;
      sb_ready = 1'b1;
    end
    if (rst) begin
      chk("rst_ack",  32'(ch_ack),   0);
      chk("rst_done", 32'(ch_done),  0);
      chk("rst_rd",   32'(ch_rd),    0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wd",   32'(mem_wd),   0);
      chk("rst_we",   32'(mem_we),   0);
      chk("rst_re",   32'(mem_re),   0);
      sbq.delete();
      tb_ptr   = 0;
      exp_re   = 1'b0;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_wd   = '0;
      exp_rd   = '0;
    end else begin
      chk("mem_re",   32'(mem_re),   32'(exp_re));
      chk("mem_we",   32'(mem_we),   32'(exp_we));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk("mem_wd",   32'(mem_wd),   32'(exp_wd));
      exp_done = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        exp_done = NCH'(1) << e.ch;
        if (e.rnw) begin
          exp_rd = e.data;
          n_rd_done++;
        end else begin
          n_wr_done++;
        end
      end
      chk("ch_done", 32'(ch_done), 32'(exp_done));
      chk("ch_rd",   32'(ch_rd),   32'(exp_rd));
`ifdef DMA_ARB_FIXED_PRIO_EN
      p = 0;
`else
      p = tb_ptr;
`endif
      win     = slot_free ? model_win(ch_req, p) : -1;
      exp_ack = (win < 0) ? '0 : (NCH'(1) << win);
      chk("ch_ack", 32'(ch_ack), 32'(exp_ack));
      if (win >= 0) begin
        exp_re   = ch_rnw[win];
        exp_we   = ~ch_rnw[win];
        exp_addr = ch_addr[win*AW +: AW];
        exp_wd   = ch_wd[win*8 +: 8];
        if (!ch_rnw[win]) sb_mem[exp_addr[7:0]] = exp_wd;
        e.due  = cyc + 2;
        e.ch   = win;
        e.rnw  = ch_rnw[win];
        e.data = sb_mem[exp_addr[7:0]];
        sbq.push_back(e);
        tb_ptr = (win + 1) % int'(NCH);
      end else begin
        exp_re = 1'b0;
        exp_we = 1'b0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on one channel; holds the request until acked (bounded).
  task automatic xfer(input int ch, input logic rnw, input logic [AW-1:0] a, input logic [7:0] d);
    bit acked;
    acked = 1'b0;
    ch_req[ch] = 1'b1;
    ch_rnw[ch] = rnw;
    ch_addr[ch*AW +: AW] = a;
    ch_wd[ch*8 +: 8] = d;
    for (int k = 0; k < 20 && !acked; k++) begin
      #1;
      acked = ch_ack[ch];
      step();
    end
    ch_req[ch] = 1'b0;
    if (!acked) chk("ack_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rd;
    int base_wr;
    int idx;
    int exp_idx;

    repeat (3) step();
    rst = 1'b0;
    slot_free = 1'b1;
    step();

    // Single read on channel 1 returns the preloaded byte.
    base_rd = n_rd_done;
    xfer(1, 1'b1, 21'h00C000, 8'h00);
    repeat (3) step();
    chk("single_rd_done", 32'(n_rd_done - base_rd), 1);
    chk("single_rd_data", 32'(ch_rd), 32'h5A);

    // 16-byte write burst then read back on channel 0.
    base_rd = n_rd_done;
    base_wr = n_wr_done;
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 21'h00C000 + 21'(i), 8'h30 + 8'(i * 7));
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, 21'h00C000 + 21'(i), 8'h00);
    repeat (4) step();
    chk("burst_wr_dones", 32'(n_wr_done - base_wr), 16);
    chk("burst_rd_dones", 32'(n_rd_done - base_rd), 16);

    // All channels requesting continuously after a reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < int'(NCH); c++) begin
      ch_rnw[c] = 1'b1;
      ch_addr[c*AW +: AW] = 21'h00C000 + 21'(c);
    end
    ch_req = '1;
    for (int k = 0; k < 12; k++) begin
      #1;
      idx = -1;
      for (int c = 0; c < int'(NCH); c++) if (ch_ack[c]) idx = c;
`ifdef DMA_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = k % int'(NCH);
`endif
      chk("rr_order", 32'(idx), 32'(exp_idx));
      step();
    end
    ch_req = '0;
    repeat (3) step();

    // Slot toggling with channels 0 and 2 writing.
    ch_rnw = '0;
    ch_addr[0*AW +: AW] = 21'h000020;
    ch_addr[2*AW +: AW] = 21'h000022;
    ch_wd[0*8 +: 8] = 8'hC0;
    ch_wd[2*8 +: 8] = 8'hC2;
    ch_req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      slot_free = ~k[0];
      step();
    end
    ch_req = '0;
    slot_free = 1'b1;
    repeat (3) step();

    // Reset one cycle after an ack kills its done; next grant goes to channel 0.
    for (int c = 0; c < int'(NCH); c++) begin
      ch_rnw[c] = 1'b1;
      ch_addr[c*AW +: AW] = 21'h00C004 + 21'(c);
    end
    xfer(2, 1'b1, 21'h00C005, 8'h00);
    rst = 1'b1;
    #1;
    chk("rst_mid_re", 32'(mem_re), 0);
    step();
    rst = 1'b0;
    ch_req = '1;
    #1;
    chk("post_rst_grant", 32'(ch_ack), 32'h1);
    step();
    ch_req = '0;
    repeat (3) step();

    // Channel 3 requests only while the slot is busy, then withdraws.
    slot_free = 1'b0;
    ch_req[3] = 1'b1;
    #1;
    chk("busy_no_ack", 32'(ch_ack), 0);
    step();
    step();
    ch_req[3] = 1'b0;
    step();
    slot_free = 1'b1;
    ch_req = 4'b1100;
    repeat (4) step();
    ch_req = '0;
    repeat (5) step();
    chk("drain", 32'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
